// File: rtl/reg_file_param_if.sv
// Register file port bundle: read ports, two write ports, scoreboard set.
// Master drives requests, slave (the register file) returns data and flags.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     init_start;
  logic                     ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we0;
  logic [ADDR_W-1:0]        wa0;
  logic [DATA_W-1:0]        wd0;
  logic                     we1;
  logic [ADDR_W-1:0]        wa1;
  logic [DATA_W-1:0]        wd1;
  logic                     set_busy;
  logic [ADDR_W-1:0]        set_addr;

  modport master (
    output init_start, rd_addr,
    output we0, wa0, wd0,
    output we1, wa1, wd1,
    output set_busy, set_addr,
    input  ready, rd_data, rd_busy
  );

  modport slave (
    input  init_start, rd_addr,
    input  we0, wa0, wd0,
    input  we1, wa1, wd1,
    input  set_busy, set_addr,
    output ready, rd_data, rd_busy
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised multi-port register file with busy scoreboard,
// write-to-read bypass and a one-entry-per-cycle init engine.
module reg_file_param #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 5,
  parameter int              NUM_RD   = 2,
  parameter bit              ZERO_REG = 1'b1,
  parameter bit              BYPASS   = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic           clock,
  input logic           reset_n,
  reg_file_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic rdy;
  logic w0;
  logic w1;
  logic sb;

  assign rdy       = (state_q == READY);
  assign bus.ready = rdy;

  // Filtered write/set strobes: READY only, not on a re-init edge,
  // and never targeting the hardwired zero register.
  assign w0 = rdy && !bus.init_start && bus.we0
              && !(ZERO_REG && bus.wa0 == '0);
  assign w1 = rdy && !bus.init_start && bus.we1
              && !(ZERO_REG && bus.wa1 == '0);
  assign sb = rdy && !bus.init_start && bus.set_busy
              && !(ZERO_REG && bus.set_addr == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (bus.init_start) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Set is applied last so it wins over a same-edge clear.
  always_comb begin
    busy_d = busy_q;
    if (w0) busy_d[bus.wa0] = 1'b0;
    if (w1) busy_d[bus.wa1] = 1'b0;
    if (sb) busy_d[bus.set_addr] = 1'b1;
    if (rdy && bus.init_start) busy_d = '0;
  end

  // Array has no reset so it can map onto RAM; port 1 lands last.
  always_ff @(posedge clock) begin
    if (!rdy) begin
      mem[cnt_q] <= INIT_VAL;
    end else begin
      if (w0) mem[bus.wa0] <= bus.wd0;
      if (w1) mem[bus.wa1] <= bus.wd1;
    end
  end

  logic [DATA_W-1:0] rd_d [NUM_RD];
  logic [NUM_RD-1:0] rd_b;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              h0;
    logic              h1;
    logic              hs;

    assign a  = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign h0 = BYPASS && w0 && (bus.wa0 == a);
    assign h1 = BYPASS && w1 && (bus.wa1 == a);
    assign hs = sb && (bus.set_addr == a);

    assign rd_d[k] = !rdy                     ? '0      :
                     (ZERO_REG && a == '0)    ? '0      :
                     h1                       ? bus.wd1 :
                     h0                       ? bus.wd0 :
                                                mem[a];

    assign rd_b[k] = !rdy                ? 1'b0 :
                     ((h0 || h1) && !hs) ? 1'b0 :
                                           busy_q[a];
  end

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = rd_d[k];
    end
  end

  assign bus.rd_busy = rd_b;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_reg_file_param;

  logic clock;
  logic reset_n;

  reg_file_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  reg_file_param #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2),
    .ZERO_REG(1'b1), .BYPASS(1'b1), .INIT_VAL(32'h0)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          kq [$];
  int          pq [$];
  logic [31:0] vq [$];
  string       nq [$];

  int checks = 0;
  int errors = 0;

  // kind 0 = rd_data[port], 1 = rd_busy[port], 2 = ready
  task automatic exp(input int k, input int p,
                     input logic [31:0] v, input string nm);
    kq.push_back(k);
    pq.push_back(p);
    vq.push_back(v);
    nq.push_back(nm);
  endtask

  int          m_k;
  int          m_p;
  logic [31:0] m_v;
  logic [31:0] m_act;
  string       m_n;

  always @(negedge clock) begin
    while (kq.size() > 0) begin
      m_k = kq.pop_front();
      m_p = pq.pop_front();
      m_v = vq.pop_front();
      m_n = nq.pop_front();
      case (m_k)
        0:       m_act = bus.rd_data[m_p*32 +: 32];
        1:       m_act = {31'b0, bus.rd_busy[m_p]};
        default: m_act = {31'b0, bus.ready};
      endcase
      checks++;
      if (m_act !== m_v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", m_n, m_act, m_v);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.we0        = 1'b0;
    bus.we1        = 1'b0;
    bus.set_busy   = 1'b0;
    bus.init_start = 1'b0;
  endtask

  task automatic rd(input int a0, input int a1);
    bus.rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic wr0(input int a, input logic [31:0] d);
    bus.we0 = 1'b1;
    bus.wa0 = 5'(a);
    bus.wd0 = d;
  endtask

  task automatic wr1(input int a, input logic [31:0] d);
    bus.we1 = 1'b1;
    bus.wa1 = 5'(a);
    bus.wd1 = d;
  endtask

  task automatic init_wait(input string nm);
    for (int i = 0; i < 32; i++) begin
      exp(2, 0, 32'd0, nm);
      if (i == 31) idle();
      tick();
    end
    exp(2, 0, 32'd1, {nm, "_done"});
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.rd_addr  = '0;
    bus.wa0      = '0;
    bus.wd0      = '0;
    bus.wa1      = '0;
    bus.wd1      = '0;
    bus.set_addr = '0;
    idle();
    exp(2, 0, 32'd0, "reset_ready");
    exp(0, 0, 32'd0, "reset_rd_data");
    exp(1, 0, 32'd0, "reset_rd_busy");
    tick();
    tick();

    // Release reset with a write to 5 held throughout INIT.
    reset_n = 1'b1;
    wr0(5, 32'hDEAD_BEEF);
    rd(5, 5);
    init_wait("por_init");
    tick();

    for (int a = 0; a < 32; a++) begin
      rd(a, 31 - a);
      exp(0, 0, 32'd0, "init_zero_p0");
      exp(0, 1, 32'd0, "init_zero_p1");
      exp(1, 0, 32'd0, "init_busy_p0");
      tick();
    end

    // Same-edge write collision: port 1 wins, also on bypass.
    wr0(3, 32'h0000_1234);
    wr1(3, 32'h0000_BEEF);
    rd(3, 3);
    exp(0, 0, 32'h0000_BEEF, "collide_bypass");
    tick();
    idle();
    exp(0, 0, 32'h0000_BEEF, "collide_stored");
    tick();

    // Zero register is never written.
    wr0(0, 32'hFFFF_FFFF);
    rd(0, 0);
    exp(0, 0, 32'd0, "zero_bypass");
    tick();
    idle();
    exp(0, 0, 32'd0, "zero_stored");
    tick();

    // Bypass from port 1 and from port 0.
    rd(7, 8);
    exp(0, 0, 32'd0, "pre_bypass7");
    tick();
    wr1(7, 32'h0000_A5A5);
    wr0(8, 32'h0000_0055);
    exp(0, 0, 32'h0000_A5A5, "bypass_w1");
    exp(0, 1, 32'h0000_0055, "bypass_w0");
    tick();
    idle();
    exp(0, 0, 32'h0000_A5A5, "stored_w1");
    exp(0, 1, 32'h0000_0055, "stored_w0");
    tick();

    // Scoreboard set, same-cycle clear, set-wins collision.
    rd(9, 0);
    bus.set_busy = 1'b1;
    bus.set_addr = 5'd9;
    exp(1, 0, 32'd0, "busy_before_set");
    tick();
    idle();
    exp(1, 0, 32'd1, "busy_set");
    tick();
    wr0(9, 32'h0000_0099);
    exp(1, 0, 32'd0, "busy_clear_bypass");
    exp(0, 0, 32'h0000_0099, "busy_clear_data");
    tick();
    idle();
    exp(1, 0, 32'd0, "busy_cleared");
    tick();
    wr0(9, 32'h0000_0077);
    bus.set_busy = 1'b1;
    bus.set_addr = 5'd9;
    exp(1, 0, 32'd0, "set_clr_same_cycle");
    tick();
    idle();
    exp(1, 0, 32'd1, "set_wins");
    exp(0, 0, 32'h0000_0077, "set_clr_data");
    tick();
    wr1(9, 32'h0000_0078);
    exp(1, 0, 32'd0, "clear_w1_bypass");
    tick();
    idle();
    exp(1, 0, 32'd0, "clear_w1");
    bus.set_busy = 1'b1;
    bus.set_addr = 5'd0;
    tick();
    idle();
    exp(1, 1, 32'd0, "zero_never_busy");
    tick();

    // Soft init clears data and busy flags.
    for (int a = 1; a <= 4; a++) begin
      wr0(a, 32'(a * 17));
      if (a == 4) begin
        bus.set_busy = 1'b1;
        bus.set_addr = 5'd2;
      end
      tick();
    end
    idle();
    rd(4, 2);
    exp(0, 0, 32'h0000_0044, "fill4");
    exp(1, 1, 32'd1, "fill_busy2");
    tick();
    rd(6, 2);
    bus.init_start = 1'b1;
    wr0(6, 32'h0000_0066);
    exp(2, 0, 32'd1, "init_edge_ready");
    exp(0, 0, 32'd0, "init_edge_no_bypass");
    exp(1, 1, 32'd1, "init_edge_busy");
    tick();
    idle();
    init_wait("soft_init");
    tick();
    rd(1, 2);
    exp(0, 0, 32'd0, "soft_rd1");
    exp(0, 1, 32'd0, "soft_rd2");
    exp(1, 1, 32'd0, "soft_busy2");
    tick();
    rd(4, 6);
    exp(0, 0, 32'd0, "soft_rd4");
    exp(0, 1, 32'd0, "soft_rd6");
    tick();

    // Reset in the middle of init restarts the count.
    bus.init_start = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    exp(2, 0, 32'd0, "mid_init_reset");
    tick();
    reset_n = 1'b1;
    init_wait("rst_reinit");
    tick();

    @(negedge clock);
    #1;
    if (kq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", kq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
